updown_count_checker: RTL and testbench

Synthesizable in-line checker that observes the control inputs and the `count` output of the 8-bit up/down counter. It predicts every next count, compares each cycle, and reports mismatches. It sits beside the counter in `top` and is the reader of the counter interface. Its verdict comes from the counter's observable behaviour alone, so it can stay in silicon as a self-check.

---
 rtl/updown_count_checker.sv | 272 +++++++++++++++++++++++++++
 tb/tb_updown_count_checker.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/updown_count_checker.sv
// ---------------------------------------------------------------------------
// updown_count_checker
//
// In-line checker for an up/down counter. It watches the counter's control
// inputs and its count output. Each cycle it predicts the next count and
// compares it with the value the counter actually shows. Because the verdict
// uses only observable behaviour, the block can stay in silicon as a
// self-check.
//
// Parameters:
//   WIDTH  - counter data width
//   ERR_W  - width of the saturating error counter (and coverage counters)
//
// Ports:
//   clk        in   rising-edge clock shared with the counter
//   rst        in   synchronous, active-high reset
//   start      in   pulse: align to the observed count and begin checking
//   stop       in   pulse: stop checking and return to idle
//   en         in   counter enable as driven to the counter
//   m          in   counter mode, 1 = up, 0 = down
//   load       in   counter synchronous load (priority over en)
//   data_in    in   counter load value
//   count      in   observed counter output
//   exp_count  out  predicted counter value
//   mismatch   out  one-cycle pulse per detected mismatch
//   err_sticky out  set on first mismatch, cleared by rst or start
//   err_cnt    out  saturating mismatch count
//   checking   out  high while the checker is in the CHECK state
//
// Optional build macro UPDOWN_CHECK_COVER_EN adds the saturating coverage
// outputs cov_up, cov_down, cov_load and cov_wrap (ERR_W bits each). They
// count CHECK-state cycles with an up step, a down step, a load, and a wrap
// of the predicted value. Without the macro these ports do not exist.
// ---------------------------------------------------------------------------
module updown_count_checker #(
  parameter int WIDTH = 8,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             m,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] exp_count,
  output logic             mismatch,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_cnt,
  output logic             checking
`ifdef UPDOWN_CHECK_COVER_EN
  ,
  output logic [ERR_W-1:0] cov_up,
  output logic [ERR_W-1:0] cov_down,
  output logic [ERR_W-1:0] cov_load,
  output logic [ERR_W-1:0] cov_wrap
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ZERO = {ERR_W{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};

  // Counter model: load wins over en; increments and decrements wrap.
  function automatic logic [WIDTH-1:0] predict_next(
    input logic [WIDTH-1:0] base,
    input logic             ld,
    input logic             en_i,
    input logic             up,
    input logic [WIDTH-1:0] ld_val
  );
    logic [WIDTH-1:0] nxt;
    if (ld) begin
      nxt = ld_val;
    end else if (en_i && up) begin
      nxt = base + CNT_ONE;
    end else if (en_i) begin
      nxt = base - CNT_ONE;
    end else begin
      nxt = base;
    end
    return nxt;
  endfunction

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    logic [ERR_W-1:0] r;
    if (v == ERR_MAX) begin
      r = v;
    end else begin
      r = v + ERR_ONE;
    end
    return r;
  endfunction

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] exp_count_r;
  logic             mismatch_r;
  logic             err_sticky_r;
  logic [ERR_W-1:0] err_cnt_r;
  logic             checking_r;

  logic             diff_s;
  logic [WIDTH-1:0] base_s;
  logic [WIDTH-1:0] pred_s;

  // Compare, choose the base value for the model, and predict the next count.
  always_comb begin
    diff_s = (count != exp_count_r);
    base_s = exp_count_r;
    case (state_r)
      // Alignment: the model starts from whatever the counter shows now.
      ST_SYNC: base_s = count;
      // On a mismatch, resync to the observed count so one fault is reported
      // once; when equal both choices give the same value.
      ST_CHECK: begin
        if (diff_s) begin
          base_s = count;
        end else begin
          base_s = exp_count_r;
        end
      end
      default: base_s = exp_count_r;
    endcase
    pred_s = predict_next(base_s, load, en, m, data_in);
  end

  // Next-state decode; start beats stop, and stop is ignored outside CHECK.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_SYNC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SYNC: state_next_s = ST_CHECK;
      ST_CHECK: begin
        if (start) begin
          state_next_s = ST_SYNC;
        end else if (stop) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_CHECK;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register, prediction register and error statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      exp_count_r  <= CNT_ZERO;
      mismatch_r   <= 1'b0;
      err_sticky_r <= 1'b0;
      err_cnt_r    <= ERR_ZERO;
      checking_r   <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      // Decoded from the next state so the flag lines up with the state.
      checking_r <= (state_next_s == ST_CHECK);
      case (state_r)
        ST_IDLE: begin
          mismatch_r <= 1'b0;
        end
        ST_SYNC: begin
          exp_count_r  <= pred_s;
          mismatch_r   <= 1'b0;
          err_sticky_r <= 1'b0;
          err_cnt_r    <= ERR_ZERO;
        end
        ST_CHECK: begin
          exp_count_r <= pred_s;
          mismatch_r  <= diff_s;
          if (diff_s) begin
            err_sticky_r <= 1'b1;
            err_cnt_r    <= sat_inc(err_cnt_r);
          end
        end
        default: begin
          mismatch_r <= 1'b0;
        end
      endcase
    end
  end

  assign exp_count  = exp_count_r;
  assign mismatch   = mismatch_r;
  assign err_sticky = err_sticky_r;
  assign err_cnt    = err_cnt_r;
  assign checking   = checking_r;

`ifdef UPDOWN_CHECK_COVER_EN
  logic             up_step_s;
  logic             down_step_s;
  logic             wrap_s;
  logic [ERR_W-1:0] cov_up_r;
  logic [ERR_W-1:0] cov_down_r;
  logic [ERR_W-1:0] cov_load_r;
  logic [ERR_W-1:0] cov_wrap_r;

  // Classify the step the model takes this cycle; a wrap is FF->00 or 00->FF.
  always_comb begin
    up_step_s   = !load && en && m;
    down_step_s = !load && en && !m;
    if (up_step_s && (base_s == {WIDTH{1'b1}})) begin
      wrap_s = 1'b1;
    end else if (down_step_s && (base_s == CNT_ZERO)) begin
      wrap_s = 1'b1;
    end else begin
      wrap_s = 1'b0;
    end
  end

  // Saturating coverage counters, active in CHECK and cleared in SYNC.
  always_ff @(posedge clk) begin
    if (rst) begin
      cov_up_r   <= ERR_ZERO;
      cov_down_r <= ERR_ZERO;
      cov_load_r <= ERR_ZERO;
      cov_wrap_r <= ERR_ZERO;
    end else begin
      case (state_r)
        ST_SYNC: begin
          cov_up_r   <= ERR_ZERO;
          cov_down_r <= ERR_ZERO;
          cov_load_r <= ERR_ZERO;
          cov_wrap_r <= ERR_ZERO;
        end
        ST_CHECK: begin
          if (up_step_s) begin
            cov_up_r <= sat_inc(cov_up_r);
          end
          if (down_step_s) begin
            cov_down_r <= sat_inc(cov_down_r);
          end
          if (load) begin
            cov_load_r <= sat_inc(cov_load_r);
          end
          if (wrap_s) begin
            cov_wrap_r <= sat_inc(cov_wrap_r);
          end
        end
        default: begin
          cov_up_r <= cov_up_r;
        end
      endcase
    end
  end

  assign cov_up   = cov_up_r;
  assign cov_down = cov_down_r;
  assign cov_load = cov_load_r;
  assign cov_wrap = cov_wrap_r;
`endif

endmodule

// File: tb/tb_updown_count_checker.sv
// ---------------------------------------------------------------------------
// Directed bench for updown_count_checker. A small up/down counter in the
// bench drives `count`; it can be upset (XOR mask applied to its register)
// or told to ignore load, to create faults for the checker to find.
// Inputs change 1 time unit after each rising edge and outputs are checked
// at that same point, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_updown_count_checker;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       en;
  logic       m;
  logic       load;
  logic [7:0] data_in;
  logic [7:0] count;
  logic [7:0] exp_count;
  logic       mismatch;
  logic       err_sticky;
  logic [7:0] err_cnt;
  logic       checking;
`ifdef UPDOWN_CHECK_COVER_EN
  logic [7:0] cov_up;
  logic [7:0] cov_down;
  logic [7:0] cov_load;
  logic [7:0] cov_wrap;
`endif

  logic       upset;
  logic [7:0] upset_mask;
  logic       ignore_load;
  logic [7:0] ctr;

  int checks;
  int errors;

  updown_count_checker #(.WIDTH(8), .ERR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .en         (en),
    .m          (m),
    .load       (load),
    .data_in    (data_in),
    .count      (count),
    .exp_count  (exp_count),
    .mismatch   (mismatch),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt),
    .checking   (checking)
`ifdef UPDOWN_CHECK_COVER_EN
    ,
    .cov_up     (cov_up),
    .cov_down   (cov_down),
    .cov_load   (cov_load),
    .cov_wrap   (cov_wrap)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter under observation, with fault hooks.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctr <= 8'h00;
    end else if (upset) begin
      ctr <= ctr ^ upset_mask;
    end else if (load && !ignore_load) begin
      ctr <= data_in;
    end else if (en && m) begin
      ctr <= ctr + 8'd1;
    end else if (en) begin
      ctr <= ctr - 8'd1;
    end
  end
  assign count = ctr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b0; m = 1'b0; load = 1'b0;
    data_in = 8'h00; upset = 1'b0; upset_mask = 8'h00; ignore_load = 1'b0;

    // Reset state
    step(); step();
    check("rst_exp", exp_count, 8'h00);
    check("rst_mismatch", mismatch, 1'b0);
    check("rst_sticky", err_sticky, 1'b0);
    check("rst_errcnt", err_cnt, 8'h00);
    check("rst_checking", checking, 1'b0);
    rst = 1'b0;

    // Start, then 10 up steps from count 0
    start = 1'b1; step();
    check("sync_checking", checking, 1'b0);
    start = 1'b0; en = 1'b1; m = 1'b1; step();
    check("check_entered", checking, 1'b1);
    check("up_exp_1", exp_count, 8'd1);
    for (int i = 2; i <= 10; i++) begin
      step();
      check("up_exp", exp_count, i);
      check("up_mismatch", mismatch, 1'b0);
    end
    check("up_errcnt", err_cnt, 8'h00);
    check("up_sticky", err_sticky, 1'b0);

    // Load FE then wrap through FF, 00, 01
    load = 1'b1; data_in = 8'hFE; step();
    check("load_fe", exp_count, 8'hFE);
    load = 1'b0; step(); step(); step();
    check("wrap_exp", exp_count, 8'h01);
    check("wrap_mismatch", mismatch, 1'b0);
    check("wrap_errcnt", err_cnt, 8'h00);
`ifdef UPDOWN_CHECK_COVER_EN
    check("cov_wrap", cov_wrap, 8'd1);
    check("cov_load", cov_load, 8'd1);
`endif

    // Single fault: counter at 20 upset to 55
    load = 1'b1; en = 1'b0; data_in = 8'h20; step();
    check("load_20", exp_count, 8'h20);
    load = 1'b0; upset = 1'b1; upset_mask = 8'h75; step();
    check("fault_pre_mismatch", mismatch, 1'b0);
    check("fault_pre_exp", exp_count, 8'h20);
    upset = 1'b0; step();
    check("fault_mismatch", mismatch, 1'b1);
    check("fault_sticky", err_sticky, 1'b1);
    check("fault_errcnt", err_cnt, 8'd1);
    check("fault_resync", exp_count, 8'h55);
    step();
    check("fault_pulse_end", mismatch, 1'b0);
    step();
    check("fault_no_repeat", mismatch, 1'b0);
    check("fault_errcnt_hold", err_cnt, 8'd1);
    check("fault_sticky_hold", err_sticky, 1'b1);

    // Load priority over a decrement
    load = 1'b1; en = 1'b1; m = 1'b0; data_in = 8'h10; step();
    check("ldprio_exp", exp_count, 8'h10);
    check("ldprio_mismatch", mismatch, 1'b0);
    ignore_load = 1'b1; step();
    check("ldprio_exp2", exp_count, 8'h10);
    load = 1'b0; en = 1'b0; ignore_load = 1'b0; step();
    check("ldprio_flag", mismatch, 1'b1);
    check("ldprio_errcnt", err_cnt, 8'd2);
    check("ldprio_resync", exp_count, 8'h0F);
    step();
    check("ldprio_pulse_end", mismatch, 1'b0);

    // Reset mid-CHECK, with a start in the same cycle
    rst = 1'b1; start = 1'b1; step();
    check("midrst_exp", exp_count, 8'h00);
    check("midrst_mismatch", mismatch, 1'b0);
    check("midrst_sticky", err_sticky, 1'b0);
    check("midrst_errcnt", err_cnt, 8'h00);
    check("midrst_checking", checking, 1'b0);
    rst = 1'b0; start = 1'b0; step();
    check("midrst_idle", checking, 1'b0);
    start = 1'b1; step();
    start = 1'b0; en = 1'b1; m = 1'b1; step();
    check("resume_checking", checking, 1'b1);
    check("resume_exp", exp_count, 8'd1);
    step();
    check("resume_exp2", exp_count, 8'd2);
    check("resume_mismatch", mismatch, 1'b0);

    // Mismatch every cycle: error counter saturates
    en = 1'b0; upset = 1'b1; upset_mask = 8'hFF;
    for (int i = 0; i < 300; i++) begin
      step();
    end
    check("sat_errcnt", err_cnt, 8'd255);
    check("sat_mismatch", mismatch, 1'b1);
    check("sat_sticky", err_sticky, 1'b1);
    step(); step(); step();
    check("sat_hold", err_cnt, 8'd255);

    // start and stop together in CHECK: start wins and statistics restart
    upset = 1'b0; start = 1'b1; stop = 1'b1; step();
    check("startstop_sync", checking, 1'b0);
    start = 1'b0; stop = 1'b0; step();
    check("restart_checking", checking, 1'b1);
    check("restart_errcnt", err_cnt, 8'h00);
    check("restart_sticky", err_sticky, 1'b0);
    check("restart_mismatch", mismatch, 1'b0);
    step();
    check("restart_clean", mismatch, 1'b0);

    // stop returns to IDLE
    stop = 1'b1; step();
    check("stop_idle", checking, 1'b0);
    stop = 1'b0; step();
    check("stop_stays", checking, 1'b0);
    check("stop_quiet", mismatch, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
